// File: rtl/bp_mem_arbiter.sv
// Round-robin arbiter sharing one memory command/response channel among num_req_p requesters.
// Issued requester ids are kept in an in-order tag FIFO that steers each response back.
module bp_mem_arbiter #(
  parameter int unsigned num_req_p            = 2,
  parameter int unsigned max_outstanding_p    = 4,
  parameter int unsigned cce_mem_msg_width_lp = 64
) (
  input  logic                                      clk_i,
  input  logic                                      reset_n_i,
  input  logic [num_req_p*cce_mem_msg_width_lp-1:0] req_cmd_i,
  input  logic [num_req_p-1:0]                      req_cmd_v_i,
  output logic [num_req_p-1:0]                      req_cmd_yumi_o,
  output logic [cce_mem_msg_width_lp-1:0]           req_resp_o,
  output logic [num_req_p-1:0]                      req_resp_v_o,
  input  logic [num_req_p-1:0]                      req_resp_yumi_i,
  output logic [cce_mem_msg_width_lp-1:0]           mem_cmd_o,
  output logic                                      mem_cmd_v_o,
  input  logic                                      mem_cmd_ready_i,
  input  logic [cce_mem_msg_width_lp-1:0]           mem_resp_i,
  input  logic                                      mem_resp_v_i,
  output logic                                      mem_resp_yumi_o,
  output logic [$clog2(max_outstanding_p+1)-1:0]    outstanding_o,
  output logic                                      error_o
);

  localparam int unsigned W     = cce_mem_msg_width_lp;
  localparam int unsigned ID_W  = $clog2(num_req_p);
  localparam int unsigned OCC_W = $clog2(max_outstanding_p + 1);
  localparam int unsigned PTR_W = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;

  logic [ID_W-1:0]  r_last;
  logic [ID_W-1:0]  r_tags [max_outstanding_p];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [OCC_W-1:0] r_occ;
  logic             r_error;

  logic             w_gnt_v;
  logic [ID_W-1:0]  w_gnt;
  logic             w_issue_ok;
  logic             w_push;
  logic             w_pop;
  logic             w_empty;
  logic [ID_W-1:0]  w_head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(max_outstanding_p - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Round-robin search starting just above the last granted requester
  always_comb begin
    int unsigned idx;
    w_gnt_v = 1'b0;
    w_gnt   = '0;
    idx     = 0;
    for (int unsigned k = 1; k <= num_req_p; k++) begin
      idx = (32'(r_last) + k) % num_req_p;
      if (!w_gnt_v && req_cmd_v_i[ID_W'(idx)]) begin
        w_gnt_v = 1'b1;
        w_gnt   = ID_W'(idx);
      end
    end
  end

  // Full check uses registered occupancy only; a same-cycle pop does not free a slot
  assign w_issue_ok = reset_n_i & mem_cmd_ready_i & (r_occ < OCC_W'(max_outstanding_p));
  assign w_push     = w_issue_ok & w_gnt_v;
  assign w_empty    = (r_occ == '0);
  assign w_head     = r_tags[r_rd_ptr];

  assign mem_cmd_v_o     = w_push;
  assign mem_resp_yumi_o = reset_n_i & mem_resp_v_i & (w_empty | req_resp_yumi_i[w_head]);
  assign w_pop           = mem_resp_yumi_o & ~w_empty;
  assign req_resp_o      = mem_resp_i;
  assign outstanding_o   = r_occ;
  assign error_o         = r_error;

  always_comb begin
    mem_cmd_o      = '0;
    req_cmd_yumi_o = '0;
    req_resp_v_o   = '0;
    for (int unsigned i = 0; i < num_req_p; i++) begin
      if (ID_W'(i) == w_gnt) mem_cmd_o = req_cmd_i[i*W +: W];
    end
    if (w_push) req_cmd_yumi_o[w_gnt] = 1'b1;
    if (reset_n_i && !w_empty && mem_resp_v_i) req_resp_v_o[w_head] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_last   <= ID_W'(num_req_p - 1);
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_occ    <= '0;
      r_error  <= 1'b0;
      for (int unsigned i = 0; i < max_outstanding_p; i++) r_tags[i] <= '0;
    end else begin
      if (w_push) begin
        r_tags[r_wr_ptr] <= w_gnt;
        r_wr_ptr         <= ptr_inc(r_wr_ptr);
        r_last           <= w_gnt;
      end
      if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_occ   <= r_occ + OCC_W'(w_push) - OCC_W'(w_pop);
      r_error <= r_error | (mem_resp_v_i & w_empty);
    end
  end

endmodule

// File: tb/tb_bp_mem_arbiter.sv
// Scoreboard bench for bp_mem_arbiter: a queue-based reference model predicts each cycle,
// a negedge monitor pops predictions and compares them with the DUT outputs.
module tb_bp_mem_arbiter;

  localparam int unsigned N    = 2;
  localparam int unsigned MAXO = 4;
  localparam int unsigned W    = 32;
  localparam int unsigned OW   = $clog2(MAXO + 1);

  logic             clk = 1'b0;
  logic             reset_n_i;
  logic [N*W-1:0]   req_cmd_i;
  logic [N-1:0]     req_cmd_v_i;
  logic [N-1:0]     req_cmd_yumi_o;
  logic [W-1:0]     req_resp_o;
  logic [N-1:0]     req_resp_v_o;
  logic [N-1:0]     req_resp_yumi_i;
  logic [W-1:0]     mem_cmd_o;
  logic             mem_cmd_v_o;
  logic             mem_cmd_ready_i;
  logic [W-1:0]     mem_resp_i;
  logic             mem_resp_v_i;
  logic             mem_resp_yumi_o;
  logic [OW-1:0]    outstanding_o;
  logic             error_o;

  always #5 clk = ~clk;

  bp_mem_arbiter #(
    .num_req_p(N), .max_outstanding_p(MAXO), .cce_mem_msg_width_lp(W)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n_i),
    .req_cmd_i(req_cmd_i), .req_cmd_v_i(req_cmd_v_i), .req_cmd_yumi_o(req_cmd_yumi_o),
    .req_resp_o(req_resp_o), .req_resp_v_o(req_resp_v_o), .req_resp_yumi_i(req_resp_yumi_i),
    .mem_cmd_o(mem_cmd_o), .mem_cmd_v_o(mem_cmd_v_o), .mem_cmd_ready_i(mem_cmd_ready_i),
    .mem_resp_i(mem_resp_i), .mem_resp_v_i(mem_resp_v_i), .mem_resp_yumi_o(mem_resp_yumi_o),
    .outstanding_o(outstanding_o), .error_o(error_o)
  );

  typedef struct {
    logic         cmd_v;
    logic [W-1:0] cmd;
    logic [N-1:0] yumi;
    logic [N-1:0] rv;
    logic         ry;
    logic [W-1:0] rdata;
    int           occ;
    logic         err;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: outstanding requester ids in issue order, last grant, sticky error
  int   tags[$];
  int   last;
  bit   err;
  int   p_g;
  bit   p_push, p_pop, p_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    tags.delete();
    last = N - 1;
    err  = 1'b0;
  endtask

  // Predict this cycle's outputs from the model and the driven inputs
  task automatic predict();
    exp_t e;
    int   g;
    bit   ok;
    ok = mem_cmd_ready_i && (tags.size() < MAXO);
    g  = -1;
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (last + k) % N;
      if (g < 0 && req_cmd_v_i[i]) g = i;
    end
    p_push  = ok && (g >= 0);
    p_g     = g;
    e.cmd_v = p_push;
    e.cmd   = '0;
    e.yumi  = '0;
    if (p_push) begin
      e.cmd     = req_cmd_i[g*W +: W];
      e.yumi[g] = 1'b1;
    end
    e.rv = '0;
    if (tags.size() > 0) begin
      if (mem_resp_v_i) e.rv[tags[0]] = 1'b1;
      e.ry  = mem_resp_v_i && req_resp_yumi_i[tags[0]];
      p_pop = e.ry;
      p_err = err;
    end else begin
      e.ry  = mem_resp_v_i;
      p_pop = 1'b0;
      p_err = err | mem_resp_v_i;
    end
    e.rdata = mem_resp_i;
    e.occ   = tags.size();
    e.err   = err;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic [N-1:0] v, input logic rdy, input logic rv, input logic [N-1:0] ry);
    for (int i = 0; i < N; i++) req_cmd_i[i*W +: W] = $urandom;
    req_cmd_v_i     = v;
    mem_cmd_ready_i = rdy;
    mem_resp_v_i    = rv;
    mem_resp_i      = $urandom;
    req_resp_yumi_i = ry;
    #1;
    predict();
  endtask

  task automatic step();
    @(posedge clk);
    if (p_pop) void'(tags.pop_front());
    if (p_push) begin
      tags.push_back(p_g);
      last = p_g;
    end
    err = p_err;
    #1;
  endtask

  task automatic cyc(input logic [N-1:0] v, input logic rdy, input logic rv, input logic [N-1:0] ry);
    drive(v, rdy, rv, ry);
    step();
  endtask

  // Monitor: compares every predicted cycle, away from the active edge
  always @(negedge clk) begin : mon
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("mem_cmd_v", 64'(mem_cmd_v_o), 64'(e.cmd_v));
      if (e.cmd_v) chk("mem_cmd", 64'(mem_cmd_o), 64'(e.cmd));
      chk("cmd_yumi", 64'(req_cmd_yumi_o), 64'(e.yumi));
      chk("resp_v", 64'(req_resp_v_o), 64'(e.rv));
      if (e.rv != '0) chk("resp_data", 64'(req_resp_o), 64'(e.rdata));
      chk("mem_resp_yumi", 64'(mem_resp_yumi_o), 64'(e.ry));
      chk("outstanding", 64'(outstanding_o), 64'(e.occ));
      chk("error", 64'(error_o), 64'(e.err));
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd_v"}, 64'(mem_cmd_v_o), 64'd0);
    chk({tag, "_cmd_yumi"}, 64'(req_cmd_yumi_o), 64'd0);
    chk({tag, "_resp_v"}, 64'(req_resp_v_o), 64'd0);
    chk({tag, "_resp_yumi"}, 64'(mem_resp_yumi_o), 64'd0);
    chk({tag, "_occ"}, 64'(outstanding_o), 64'd0);
    chk({tag, "_err"}, 64'(error_o), 64'd0);
  endtask

  initial begin
    logic [N-1:0] steer [3];
    steer = '{2'b10, 2'b01, 2'b10};

    reset_n_i       = 1'b0;
    req_cmd_i       = '0;
    req_cmd_v_i     = '1;
    mem_cmd_ready_i = 1'b1;
    mem_resp_i      = '0;
    mem_resp_v_i    = 1'b1;
    req_resp_yumi_i = '1;
    model_reset();
    #3;
    chk_reset_outputs("rst0");
    repeat (2) @(posedge clk);
    #1;
    reset_n_i = 1'b1;

    // Fairness: both valid, prompt responses
    for (int k = 0; k < 4; k++) begin
      drive(2'b11, 1'b1, tags.size() > 0, 2'b11);
      chk("fair_gnt", 64'(req_cmd_yumi_o), 64'(1 << (k % 2)));
      step();
    end
    cyc(2'b00, 1'b1, 1'b1, 2'b11);
    chk("fair_drain", 64'(outstanding_o), 64'd0);

    // Single requester fills the FIFO, fifth request waits
    for (int k = 0; k < 4; k++) begin
      drive(2'b01, 1'b1, 1'b0, 2'b00);
      chk("single_yumi", 64'(req_cmd_yumi_o), 64'd1);
      step();
    end
    chk("single_full", 64'(outstanding_o), 64'd4);
    for (int k = 0; k < 2; k++) begin
      drive(2'b01, 1'b1, 1'b0, 2'b00);
      chk("held_yumi", 64'(req_cmd_yumi_o), 64'd0);
      step();
    end
    // Full boundary: pop does not enable a same-cycle push
    drive(2'b01, 1'b1, 1'b1, 2'b01);
    chk("full_no_gnt", 64'(req_cmd_yumi_o), 64'd0);
    chk("full_pop", 64'(mem_resp_yumi_o), 64'd1);
    step();
    drive(2'b01, 1'b1, 1'b0, 2'b00);
    chk("full_next_gnt", 64'(req_cmd_yumi_o), 64'd1);
    step();
    chk("full_occ", 64'(outstanding_o), 64'd4);
    repeat (4) cyc(2'b00, 1'b1, 1'b1, 2'b11);
    chk("drain", 64'(outstanding_o), 64'd0);

    // In-order steering
    cyc(2'b10, 1'b1, 1'b0, 2'b00);
    cyc(2'b01, 1'b1, 1'b0, 2'b00);
    cyc(2'b10, 1'b1, 1'b0, 2'b00);
    chk("steer_occ", 64'(outstanding_o), 64'd3);
    for (int k = 0; k < 3; k++) begin
      drive(2'b00, 1'b1, 1'b1, 2'b11);
      chk("steer_v", 64'(req_resp_v_o), 64'(steer[k]));
      step();
      chk("steer_occ_dec", 64'(outstanding_o), 64'(2 - k));
    end

    // Back-pressure from the head; non-head yumi ignored
    cyc(2'b01, 1'b1, 1'b0, 2'b00);
    for (int k = 0; k < 5; k++) begin
      drive(2'b00, 1'b1, 1'b1, 2'b10);
      chk("bp_no_yumi", 64'(mem_resp_yumi_o), 64'd0);
      step();
      chk("bp_occ", 64'(outstanding_o), 64'd1);
    end
    drive(2'b00, 1'b1, 1'b1, 2'b01);
    chk("bp_yumi", 64'(mem_resp_yumi_o), 64'd1);
    step();
    chk("bp_pop", 64'(outstanding_o), 64'd0);

    // Unexpected response
    drive(2'b00, 1'b1, 1'b1, 2'b00);
    chk("unexp_yumi", 64'(mem_resp_yumi_o), 64'd1);
    chk("unexp_resp_v", 64'(req_resp_v_o), 64'd0);
    chk("unexp_err_pre", 64'(error_o), 64'd0);
    step();
    chk("unexp_err", 64'(error_o), 64'd1);

    // Mid-burst asynchronous reset
    cyc(2'b01, 1'b1, 1'b0, 2'b00);
    cyc(2'b10, 1'b1, 1'b0, 2'b00);
    req_cmd_v_i     = 2'b11;
    mem_cmd_ready_i = 1'b1;
    mem_resp_v_i    = 1'b1;
    req_resp_yumi_i = 2'b11;
    reset_n_i       = 1'b0;
    #1;
    chk_reset_outputs("rst_mid");
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_n_i = 1'b1;
    cyc(2'b00, 1'b1, 1'b1, 2'b11);

    // Randomized traffic
    for (int k = 0; k < 1500; k++) begin
      logic rv;
      rv = ($urandom_range(0, 15) == 0) || ((tags.size() > 0) && ($urandom_range(0, 1) == 1));
      cyc(N'($urandom), $urandom_range(0, 3) != 0, rv, N'($urandom));
    end

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
